// File: rtl/product_frame_receiver.sv
// Serial receiver for the booth multiplier's product link: start bit, DATA_BITS LSB-first
// payload bits, stop bit, one bit per CLK. Reassembles the product and counts good/bad frames.
module product_frame_receiver #(
    parameter int DATA_BITS = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   rx,
    output logic [DATA_BITS-1:0]   product,
    output logic [DATA_BITS/2-1:0] product_hi,
    output logic [DATA_BITS/2-1:0] product_lo,
    output logic                   product_valid,
    output logic                   frame_err,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   frame_cnt,
    output logic [CNT_WIDTH-1:0]   err_cnt
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA    = 2'd1,
        S_STOP    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [DATA_BITS-1:0]   product_q,   product_d;
    logic                   valid_q,     valid_d;
    logic                   err_q,       err_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q,   err_cnt_d;

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            shift_q     <= {DATA_BITS{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            product_q   <= {DATA_BITS{1'b0}};
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= {CNT_WIDTH{1'b0}};
            err_cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            product_q   <= product_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state logic: every rising edge consumes exactly one line sample.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        product_d   = product_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rx == 1'b0) begin
                    state_d = S_DATA;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                shift_d[idx_q] = rx;
                if (idx_q == LAST_IDX) begin
                    state_d = S_STOP;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_STOP: begin
                if (rx == 1'b1) begin
                    product_d   = shift_q;
                    valid_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    state_d     = S_IDLE;
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    state_d = S_RECOVER;
                end
            end
            // A held-low line (break) must go high before a new start bit is accepted.
            S_RECOVER: begin
                if (rx == 1'b1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RECOVER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign product       = product_q;
    assign product_hi    = product_q[DATA_BITS-1:DATA_BITS/2];
    assign product_lo    = product_q[DATA_BITS/2-1:0];
    assign product_valid = valid_q;
    assign frame_err     = err_q;
    assign busy          = (state_q == S_DATA) || (state_q == S_STOP);
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_product_frame_receiver.sv
// Directed bench for product_frame_receiver: frames are driven bit by bit and every
// result is compared against hand-computed values.
`timescale 1ns/1ps
module tb_product_frame_receiver;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] product;
    logic [3:0] product_hi;
    logic [3:0] product_lo;
    logic       product_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int last_start = 0;
    int valid_cnt  = 0;
    int err_pulses = 0;
    int busy_seen  = 0;
    int valid_edges[$];
    int lat;

    product_frame_receiver #(.DATA_BITS(8), .CNT_WIDTH(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .rx            (rx),
        .product       (product),
        .product_hi    (product_hi),
        .product_lo    (product_lo),
        .product_valid (product_valid),
        .frame_err     (frame_err),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Pulse monitor; a pulse seen here is the one sampled at edge cyc+1.
    initial forever begin
        @(negedge CLK);
        if (product_valid) begin
            valid_edges.push_back(cyc + 1);
            valid_cnt++;
        end
        if (frame_err) err_pulses++;
        if (busy) busy_seen++;
        if (product_valid || frame_err) check("excl", {31'd0, product_valid & frame_err}, 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input bit chk_busy);
        send_bit(1'b0);
        last_start = cyc;
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (chk_busy) check("busy_in_frame", {31'd0, busy}, 32'd1);
        send_bit(stop);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        rx  = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        send_bit(1'b1);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_product", {24'd0, product}, 32'h00);
        check("rst_valid", {31'd0, product_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fcnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_ecnt", {24'd0, err_cnt}, 32'd0);
        do_reset();

        // Single frame 0xF4 (-12); valid must be seen at edge start+10
        valid_edges.delete();
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'hF4, 1'b1, 1'b1);
        check("f4_product", {24'd0, product}, 32'hF4);
        check("f4_hi", {28'd0, product_hi}, 32'hF);
        check("f4_lo", {28'd0, product_lo}, 32'h4);
        check("f4_valid", {31'd0, product_valid}, 32'd1);
        check("f4_err", {31'd0, frame_err}, 32'd0);
        check("f4_fcnt", {24'd0, frame_cnt}, 32'd1);
        send_bit(1'b1);
        check("f4_valid_drop", {31'd0, product_valid}, 32'd0);
        check("f4_pulses", valid_edges.size(), 32'd1);
        lat = (valid_edges.size() > 0) ? valid_edges[0] - last_start : -1;
        check("f4_latency", lat, 32'd10);

        // Back-to-back 0x15 then 0x80 with no idle gap
        do_reset();
        valid_edges.delete();
        send_frame(8'h15, 1'b1, 1'b1);
        check("b2b_first", {24'd0, product}, 32'h15);
        send_frame(8'h80, 1'b1, 1'b1);
        check("b2b_second", {24'd0, product}, 32'h80);
        check("b2b_hi", {28'd0, product_hi}, 32'h8);
        send_bit(1'b1);
        check("b2b_fcnt", {24'd0, frame_cnt}, 32'd2);
        check("b2b_pulses", valid_edges.size(), 32'd2);
        lat = (valid_edges.size() > 1) ? valid_edges[1] - valid_edges[0] : -1;
        check("b2b_spacing", lat, 32'd10);

        // Framing error on 0x3C, line held low (break), then good 0x07
        err_pulses = 0;
        valid_cnt  = 0;
        send_frame(8'h3C, 1'b0, 1'b1);
        check("ferr_pulse", {31'd0, frame_err}, 32'd1);
        check("ferr_valid", {31'd0, product_valid}, 32'd0);
        check("ferr_product", {24'd0, product}, 32'h80);
        check("ferr_ecnt", {24'd0, err_cnt}, 32'd1);
        busy_seen = 0;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("ferr_break_busy", busy_seen, 32'd0);
        check("ferr_once", err_pulses, 32'd1);
        check("ferr_no_valid", valid_cnt, 32'd0);
        send_bit(1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        check("ferr_next_prod", {24'd0, product}, 32'h07);
        check("ferr_next_valid", {31'd0, product_valid}, 32'd1);
        check("ferr_next_fcnt", {24'd0, frame_cnt}, 32'd3);

        // Reset after 4 data bits of 0xAA must clear everything asynchronously
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        RST = 1'b1;
        #1;
        check("mrst_product", {24'd0, product}, 32'h00);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_fcnt", {24'd0, frame_cnt}, 32'd0);
        check("mrst_ecnt", {24'd0, err_cnt}, 32'd0);
        check("mrst_valid", {31'd0, product_valid}, 32'd0);
        rx = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        send_bit(1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("mrst_5a", {24'd0, product}, 32'h5A);
        check("mrst_5a_fcnt", {24'd0, frame_cnt}, 32'd1);

        // Idle line for 100 cycles
        send_bit(1'b1);
        valid_cnt = 0;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) send_bit(1'b1);
        check("idle_valid", valid_cnt, 32'd0);
        check("idle_busy", busy_seen, 32'd0);
        check("idle_fcnt", {24'd0, frame_cnt}, 32'd1);
        check("idle_ecnt", {24'd0, err_cnt}, 32'd0);

        // frame_cnt wraps after 256 good frames
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 254) check("wrap_fcnt_255", {24'd0, frame_cnt}, 32'hFF);
        end
        check("wrap_fcnt", {24'd0, frame_cnt}, 32'd0);
        check("wrap_product", {24'd0, product}, 32'hFF);

        // err_cnt saturates after 260 bad-stop frames
        do_reset();
        for (int i = 0; i < 260; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
            send_bit(1'b1);
            if (i == 253) check("sat_ecnt_254", {24'd0, err_cnt}, 32'hFE);
        end
        check("sat_ecnt", {24'd0, err_cnt}, 32'hFF);
        check("sat_product", {24'd0, product}, 32'h00);
        check("sat_fcnt", {24'd0, frame_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
